// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states,
// opcode classes, PC source and writeback select codes.
package cpu_ctrl_pkg;

    // Debug-visible state encoding; the numeric values appear on the state port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_FAULT     = 3'd7
    } stateT;

    // Instruction classes the sequencer distinguishes.
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_MEM,
        CLS_ALU,
        CLS_SHIFT,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_COPY,
        CLS_HALT
    } opClassT;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // PC source select.
    localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Register-file writeback source select.
    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_SHIFT = 2'b01;
    localparam logic [1:0] WB_SEL_MEM   = 2'b10;
    localparam logic [1:0] WB_SEL_COPY  = 2'b11;

    // Map a 4-bit opcode onto its instruction class.
    function automatic opClassT classifyOp(input logic [3:0] op);
        opClassT cls;
        case (op)
            OP_NOP:                             cls = CLS_NOP;
            4'b0001, 4'b0010:                   cls = CLS_MEM;
            4'b0011, 4'b0100, 4'b0111, 4'b1000: cls = CLS_ALU;
            4'b0101, 4'b0110:                   cls = CLS_SHIFT;
            4'b1001, 4'b1010, 4'b1011:          cls = CLS_BRANCH;
            4'b1100, 4'b1101:                   cls = CLS_JUMP;
            4'b1110:                            cls = CLS_COPY;
            default:                            cls = CLS_HALT;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request spends waiting for memReady and flags
// when the wait budget is used up.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    // The counter holds the number of wait cycles already completed; when it
    // equals MEM_TIMEOUT-1, the current wait cycle is the last one allowed, so
    // the edge ending it is the one on which the count reaches MEM_TIMEOUT.
    localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Wait-cycle counter: clear wins over enable, and it never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST_WAIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: walks each instruction through fetch, decode,
// execute, memory and writeback, driving the PC/IR/register-file enables and
// the shared memory-port handshake.
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       func1,
    input  logic       branchTaken,
    input  logic       memReady,
    output logic       memReq,
    output logic       memWe,
    output logic       irLoad,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       regWrite,
    output logic [1:0] wbSel,
    output logic [2:0] state,
    output logic       retired,
    output logic       halted,
    output logic       fault
);

    stateT   stateQ;
    stateT   nextState;
    stateT   retireTarget;
    opClassT opClass;
    logic    timerClear;
    logic    timerEnable;
    logic    timerExpired;

    assign opClass      = classifyOp(opcode);
    assign state        = stateQ;
    // Any state change clears the wait counter, so entry to FETCH or MEM
    // always starts counting from zero (including MEM -> FETCH on a store).
    assign timerClear   = (nextState != stateQ);
    assign timerEnable  = memReq && !memReady;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uMemWaitTimer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (timerClear),
        .enable (timerEnable),
        .expired(timerExpired)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= nextState;
        end
    end

    // Next-state and output decode; outputs are combinational in the state
    // and the live IR / comparator / memory inputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        nextState    = stateQ;
        retireTarget = start ? ST_FETCH : ST_IDLE;
        memReq       = 1'b0;
        memWe        = 1'b0;
        irLoad       = 1'b0;
        pcWrite      = 1'b0;
        pcSrc        = PC_SRC_NEXT;
        regWrite     = 1'b0;
        wbSel        = WB_SEL_ALU;
        retired      = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;

        case (stateQ)
            ST_IDLE: begin
                if (start) begin
                    nextState = ST_FETCH;
                end
            end

            ST_FETCH: begin
                memReq = 1'b1;
                if (memReady) begin
                    irLoad    = 1'b1;
                    nextState = ST_DECODE;
                end else if (timerExpired) begin
                    nextState = ST_FAULT;
                end
            end

            ST_DECODE: begin
                nextState = (opClass == CLS_HALT) ? ST_HALT : ST_EXECUTE;
            end

            ST_EXECUTE: begin
                case (opClass)
                    CLS_NOP: begin
                        pcWrite   = 1'b1;
                        retired   = 1'b1;
                        nextState = retireTarget;
                    end
                    CLS_BRANCH: begin
                        pcWrite   = 1'b1;
                        pcSrc     = branchTaken ? PC_SRC_BRANCH : PC_SRC_NEXT;
                        retired   = 1'b1;
                        nextState = retireTarget;
                    end
                    CLS_JUMP: begin
                        pcWrite   = 1'b1;
                        pcSrc     = PC_SRC_JUMP;
                        retired   = 1'b1;
                        nextState = retireTarget;
                    end
                    CLS_MEM: begin
                        nextState = ST_MEM;
                    end
                    CLS_ALU, CLS_SHIFT, CLS_COPY: begin
                        nextState = ST_WRITEBACK;
                    end
                    default: begin
                        // HALT is diverted in DECODE; the IR is stable from
                        // then on, so this only guards against a corrupt IR.
                        nextState = ST_HALT;
                    end
                endcase
            end

            ST_MEM: begin
                memReq = 1'b1;
                memWe  = func1;
                if (memReady) begin
                    if (func1) begin
                        pcWrite   = 1'b1;
                        retired   = 1'b1;
                        nextState = retireTarget;
                    end else begin
                        nextState = ST_WRITEBACK;
                    end
                end else if (timerExpired) begin
                    nextState = ST_FAULT;
                end
            end

            ST_WRITEBACK: begin
                regWrite = 1'b1;
                case (opClass)
                    CLS_SHIFT: wbSel = WB_SEL_SHIFT;
                    CLS_MEM:   wbSel = WB_SEL_MEM;
                    CLS_COPY:  wbSel = WB_SEL_COPY;
                    default:   wbSel = WB_SEL_ALU;
                endcase
                pcWrite   = 1'b1;
                retired   = 1'b1;
                nextState = retireTarget;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            ST_FAULT: begin
                fault = 1'b1;
            end

            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a cycle-by-cycle vector table
// for the normal instruction flows, plus hand-written sequences for reset,
// timeout and HALT corner cases. Built with MEM_TIMEOUT=3.
module tb_multicycle_sequencer;

    typedef struct packed {
        logic       start;
        logic [3:0] opcode;
        logic       func1;
        logic       branchTaken;
        logic       memReady;
    } stimT;

    typedef struct packed {
        logic [2:0] st;
        logic       memReq;
        logic       memWe;
        logic       irLoad;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       regWrite;
        logic [1:0] wbSel;
        logic       retired;
        logic       halted;
        logic       fault;
    } outT;

    typedef struct packed {
        stimT stim;
        outT  want;
    } vecT;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [3:0] opcode;
    logic       func1;
    logic       branchTaken;
    logic       memReady;
    logic       memReq;
    logic       memWe;
    logic       irLoad;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       regWrite;
    logic [1:0] wbSel;
    logic [2:0] state;
    logic       retired;
    logic       halted;
    logic       fault;

    int compared = 0;
    int mismatched = 0;
    vecT vecs[$];

    multicycle_sequencer #(
        .MEM_TIMEOUT(3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .func1      (func1),
        .branchTaken(branchTaken),
        .memReady   (memReady),
        .memReq     (memReq),
        .memWe      (memWe),
        .irLoad     (irLoad),
        .pcWrite    (pcWrite),
        .pcSrc      (pcSrc),
        .regWrite   (regWrite),
        .wbSel      (wbSel),
        .state      (state),
        .retired    (retired),
        .halted     (halted),
        .fault      (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
        compared++;
        if (actual !== want) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, want);
        end
    endtask

    function automatic outT sampleOuts();
        return {state, memReq, memWe, irLoad, pcWrite, pcSrc, regWrite, wbSel,
                retired, halted, fault};
    endfunction

    // One row = one clock cycle: inputs applied, outputs expected that cycle.
    function automatic void addRow(
        input logic s, input logic [3:0] op, input logic f, input logic bt, input logic rdy,
        input logic [2:0] st, input logic rq, input logic we, input logic ir, input logic pw,
        input logic [1:0] ps, input logic rw, input logic [1:0] wb, input logic rt
    );
        vecT v;
        v.stim = '{start: s, opcode: op, func1: f, branchTaken: bt, memReady: rdy};
        v.want = '{st: st, memReq: rq, memWe: we, irLoad: ir, pcWrite: pw, pcSrc: ps,
                   regWrite: rw, wbSel: wb, retired: rt, halted: 1'b0, fault: 1'b0};
        vecs.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        start = 1'b0;
        memReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        opcode      = 4'b0000;
        func1       = 1'b0;
        branchTaken = 1'b0;
        memReady    = 1'b0;

        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outputs", 32'(sampleOuts()), 32'd0);
        doReset();

        // s  op       f  bt rdy | st   rq we ir pw ps     rw wb     rt
        // ALU 0011: states 1,2,3,5
        addRow(1, 4'b0011, 0, 0, 1,  3'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0011, 0, 0, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0011, 0, 0, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0011, 0, 0, 1,  3'd3, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0011, 0, 0, 1,  3'd5, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1);
        // Shift 0101
        addRow(1, 4'b0101, 0, 0, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0101, 0, 0, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0101, 0, 0, 1,  3'd3, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0101, 0, 0, 1,  3'd5, 0, 0, 0, 1, 2'b00, 1, 2'b01, 1);
        // Copy 1110
        addRow(1, 4'b1110, 0, 0, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1110, 0, 0, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1110, 0, 0, 1,  3'd3, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1110, 0, 0, 1,  3'd5, 0, 0, 0, 1, 2'b00, 1, 2'b11, 1);
        // NOP 0000: retires in EXECUTE
        addRow(1, 4'b0000, 0, 0, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0000, 0, 0, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0000, 0, 0, 1,  3'd3, 0, 0, 0, 1, 2'b00, 0, 2'b00, 1);
        // Branch 1001 taken
        addRow(1, 4'b1001, 0, 1, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1001, 0, 1, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1001, 0, 1, 1,  3'd3, 0, 0, 0, 1, 2'b01, 0, 2'b00, 1);
        // Branch 1001 not taken
        addRow(1, 4'b1001, 0, 0, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1001, 0, 0, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1001, 0, 0, 1,  3'd3, 0, 0, 0, 1, 2'b00, 0, 2'b00, 1);
        // Jump 1101 (branchTaken irrelevant)
        addRow(1, 4'b1101, 0, 1, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1101, 0, 1, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1101, 0, 1, 1,  3'd3, 0, 0, 0, 1, 2'b10, 0, 2'b00, 1);
        // Load 0001/f0, memReady low 2 cycles in MEM: 7 cycles, start dropped at retire
        addRow(1, 4'b0001, 0, 0, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0001, 0, 0, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0001, 0, 0, 1,  3'd3, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0001, 0, 0, 0,  3'd4, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0001, 0, 0, 0,  3'd4, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0001, 0, 0, 1,  3'd4, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(0, 4'b0001, 0, 0, 1,  3'd5, 0, 0, 0, 1, 2'b00, 1, 2'b10, 1);
        // IDLE ignores memReady
        addRow(0, 4'b0001, 0, 0, 1,  3'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        // Store 0001/f1 with one FETCH wait (opcode churn there ignored);
        // start dropped in EXECUTE, store still completes, then IDLE
        addRow(1, 4'b0001, 1, 0, 1,  3'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b1111, 1, 0, 0,  3'd1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0001, 1, 0, 1,  3'd1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
        addRow(1, 4'b0001, 1, 0, 1,  3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(0, 4'b0001, 1, 0, 1,  3'd3, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        addRow(0, 4'b0001, 1, 0, 1,  3'd4, 1, 1, 0, 1, 2'b00, 0, 2'b00, 1);
        addRow(0, 4'b0001, 1, 0, 1,  3'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            start       = vecs[i].stim.start;
            opcode      = vecs[i].stim.opcode;
            func1       = vecs[i].stim.func1;
            branchTaken = vecs[i].stim.branchTaken;
            memReady    = vecs[i].stim.memReady;
            #2;
            check($sformatf("vec%0d", i), 32'(sampleOuts()), 32'(vecs[i].want));
            cyc();
        end

        // FETCH timeout: three waiting cycles with MEM_TIMEOUT=3 -> FAULT.
        doReset();
        opcode = 4'b0011;
        func1 = 1'b0;
        start = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("fetch_wait%0d_state", k), 32'(state), 32'd1);
            check($sformatf("fetch_wait%0d_fault", k), 32'(fault), 32'd0);
            cyc();
        end
        #2;
        check("timeout_state", 32'(state), 32'd7);
        check("timeout_fault", 32'(fault), 32'd1);
        check("timeout_memreq", 32'(memReq), 32'd0);
        memReady = 1'b1;
        repeat (3) cyc();
        #2;
        check("fault_sticky_state", 32'(state), 32'd7);
        check("fault_sticky_outs", 32'({memReq, pcWrite, regWrite, fault}), 32'b0001);

        // memReady arriving on the third waiting cycle wins over the timeout.
        doReset();
        start = 1'b1;
        cyc();
        cyc();
        cyc();
        memReady = 1'b1;
        #2;
        check("late_ready_irload", 32'(irLoad), 32'd1);
        cyc();
        #2;
        check("late_ready_state", 32'(state), 32'd2);
        check("late_ready_fault", 32'(fault), 32'd0);

        // MEM timeout on a store.
        doReset();
        opcode = 4'b0010;
        func1 = 1'b1;
        start = 1'b1;
        memReady = 1'b1;
        cyc();
        cyc();
        cyc();
        memReady = 1'b0;
        cyc();
        #2;
        check("mem_wait_state", 32'(state), 32'd4);
        check("mem_wait_memwe", 32'(memWe), 32'd1);
        repeat (3) cyc();
        #2;
        check("mem_timeout_state", 32'(state), 32'd7);

        // Asynchronous reset mid-FETCH drops memReq within the cycle.
        doReset();
        start = 1'b1;
        memReady = 1'b0;
        cyc();
        #2;
        check("pre_reset_memreq", 32'(memReq), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_memreq", 32'(memReq), 32'd0);
        check("async_reset_state", 32'(state), 32'd0);
        start = 1'b0;
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("post_reset%0d_state", k), 32'(state), 32'd0);
            check($sformatf("post_reset%0d_retired", k), 32'(retired), 32'd0);
            cyc();
        end

        // HALT opcode: terminal, memReq stays low, later opcode changes ignored.
        doReset();
        start = 1'b1;
        memReady = 1'b1;
        opcode = 4'b1111;
        func1 = 1'b0;
        cyc();
        #2;
        check("halt_fetch_irload", 32'(irLoad), 32'd1);
        cyc();
        #2;
        check("halt_decode_state", 32'(state), 32'd2);
        cyc();
        opcode = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("halt%0d_state", k), 32'(state), 32'd6);
            check($sformatf("halt%0d_outs", k),
                  32'({halted, memReq, pcWrite, regWrite, retired}), 32'b10000);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM that sequences the CPU datapath one instruction at a time: fetch, decode, execute, memory and writeback. It consumes the 4-bit opcode and func1 bit held in the instruction register. It drives the PC, IR, register-file and memory-handshake enables that the combinational control decoder does not provide. It sits between the instruction register, the branch comparator, and the shared instruction/data memory port.

Parameters:
MEM_TIMEOUT, 15, maximum cycles a memory request may wait for memReady before entering FAULT (legal range 1..255).

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  run enable, sampled at instruction boundaries
opcode  input  4  IR opcode field, stable from DECODE onward
func1  input  1  IR func1 bit
branchTaken  input  1  comparator result, valid in EXECUTE
memReady  input  1  memory completes the current request this cycle
memReq  output  1  memory request, held until memReady
memWe  output  1  1 = write (store), 0 = read; meaningful only with memReq
irLoad  output  1  load IR from memory read data
pcWrite  output  1  update PC this cycle
pcSrc  output  2  00 PC+1, 01 branch target, 10 jump target
regWrite  output  1  register-file write enable
wbSel  output  2  00 ALU, 01 shifter, 10 memory data, 11 copy source
state  output  3  current FSM state (debug)
retired  output  1  one-cycle pulse on instruction completion
halted  output  1  high in HALT
fault  output  1  high in FAULT

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; timeout counter 0; memReq drops immediately, even mid-request.
- Outputs are combinational in state, opcode, func1, branchTaken and memReady. They are glitch-free per cycle. All outputs are 0 except where listed below.
- Opcode classes:
  - 0000 NOP
  - 0001/0010 memory: func1=0 load, func1=1 store
  - 0011, 0100, 0111, 1000 ALU
  - 0101/0110 shift
  - 1001–1011 branch
  - 1100/1101 jump
  - 1110 copy
  - 1111 HALT
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6, FAULT=7.
- IDLE: go to FETCH when start=1.
- FETCH:
  - memReq=1, memWe=0.
  - When memReady=1: irLoad=1, then go to DECODE.
- DECODE: opcode 1111 goes to HALT; all other opcodes go to EXECUTE.
- EXECUTE:
  - NOP: pcWrite=1, pcSrc=00, retire.
  - Branch: pcWrite=1, pcSrc=01 if branchTaken else 00, retire.
  - Jump: pcWrite=1, pcSrc=10, retire.
  - Memory: go to MEM.
  - ALU, shift, copy: go to WRITEBACK.
- MEM:
  - memReq=1, memWe=func1.
  - Load with memReady: go to WRITEBACK.
  - Store with memReady: pcWrite=1, pcSrc=00, retire.
- WRITEBACK:
  - regWrite=1; wbSel is 00 ALU, 01 shift, 10 load, 11 copy.
  - pcWrite=1, pcSrc=00, retire.
- Retire: retired=1 that cycle. Next state is FETCH if start=1, else IDLE.
  - start deasserted mid-instruction never aborts it; the instruction completes first.
- Latency with memReady already high:
  - branch, jump, NOP: 3 cycles
  - ALU, shift, copy, store: 4 cycles
  - load: 5 cycles
  - Each wait cycle on memReady adds 1.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle memReq=1 and memReady=0.
  - If the counter reaches MEM_TIMEOUT with memReady still 0, go to FAULT on that edge.
  - memReady=1 on the same cycle wins; no fault.
- HALT and FAULT are terminal until reset. In both, memReq, pcWrite and regWrite are 0. halted or fault =1 respectively.
- memReady while memReq=0 is ignored.
- An opcode change outside DECODE/EXECUTE/MEM/WRITEBACK is ignored.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state encoding constants
  - opcode class constants, including HALT=4'b1111
  - pcSrc and wbSel encodings
- One sub-module, mem_wait_timer: clear/enable counter with an expired flag, width derived from MEM_TIMEOUT.

Test Plan:
- Reset mid-FETCH with memReq=1 → memReq=0 within the same cycle; state=0 after reset_n rises; no retired pulse.
- start=1, opcode=0011, memReady=1 → states 1,2,3,5; regWrite=1 and wbSel=00 in cycle 4; retired pulses in cycle 4.
- Load (0001, func1=0), memReady low 2 cycles in MEM → 7 cycles total; wbSel=10 with regWrite=1 in the last cycle; memWe=0 throughout.
- Branch 1001 with branchTaken=1, then again with branchTaken=0 → pcSrc=01 then 00, each in cycle 3; pcWrite=1 both times; regWrite never 1.
- MEM_TIMEOUT=3, memReady held 0 in FETCH → fault=1 and state=7 after 3 waiting cycles. A second run with memReady on the 3rd cycle → no fault.
- start dropped during EXECUTE of store 0001/func1=1 → store completes with memWe=1; then state=IDLE. Separately, opcode 1111 → HALT with halted=1, memReq=0 forever.
